// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_det_pkg
//  Brief    : Shared types and defaults for the programmable sequence
//             detector (controller state encoding, default sizes, length
//             clamp helper).
//  Revision : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Default sizing
    localparam int MAX_LEN_DEFAULT = 8;
    localparam int LEN_W_DEFAULT   = 4;
    localparam int CNT_W_DEFAULT   = 8;

    // Classic fixed detector pattern, handy as a reference configuration
    localparam logic [3:0] PATTERN_DEFAULT = 4'b1011;

    // A zero length means a single-bit pattern; anything beyond the shift
    // register depth is limited to the full depth.
    function automatic int clamp_len(input int len, input int max_len);
        if (len <= 0)
            return 1;
        else if (len > max_len)
            return max_len;
        else
            return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_match_core.sv
`default_nettype none
// ============================================================================
//  Module   : seq_match_core
//  Brief    : Serial shift register, fill counter and length-masked pattern
//             compare. hit is combinational on the post-shift view so the
//             controller can register it into a Moore-style match pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_match_core #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               shift_en,
    input  logic               in_bit,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    output logic               hit
);

    logic [MAX_LEN-1:0] shreg;
    logic [MAX_LEN-1:0] shreg_next;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_next;

    // Post-shift view of history and fill, and the masked compare on it
    always_comb begin
        shreg_next = {shreg[MAX_LEN-2:0], in_bit};
        fill_next  = (fill >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : fill + LEN_W'(1);
        mask       = {MAX_LEN{1'b1}} >> (MAX_LEN - int'(len));
        hit        = shift_en && (fill_next >= len) &&
                     ((shreg_next & mask) == (pattern & mask));
    end

    // History update; a non-overlapping hit restarts the fill so the next
    // match needs a full set of fresh bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
            fill  <= '0;
        end else if (clear) begin
            shreg <= '0;
            fill  <= '0;
        end else if (shift_en) begin
            shreg <= shreg_next;
            fill  <= (hit && !overlap) ? '0 : fill_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_det_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seq_det_ctrl
//  Brief    : Programmable serial sequence detector with run controller.
//             Config handshake, start/stop sequencing, saturating match
//             counter and target-based completion.
//             Optional macro SEQ_DET_CTRL_POS_EN adds bit_cnt / last_pos
//             position reporting outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEFAULT,
    parameter int LEN_W   = LEN_W_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               stop,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done
`ifdef SEQ_DET_CTRL_POS_EN
    ,
    output logic [15:0]        bit_cnt,
    output logic [15:0]        last_pos
`endif
);

    state_t             state;
    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic [CNT_W-1:0]   target_q;

    logic               accept;
    logic               start_run;
    logic               shift_en;
    logic               hit;
    logic [LEN_W-1:0]   len_clamped;
    logic [CNT_W-1:0]   cnt_inc;

    // Handshake, run qualifiers and saturating increment
    always_comb begin
        cfg_ready   = (state != RUN);
        busy        = (state == RUN);
        accept      = cfg_valid && cfg_ready;
        // A config in the same cycle wins over start
        start_run   = start && !accept && ((state == ARMED) || (state == DONE));
        // stop discards any bit presented with it
        shift_en    = (state == RUN) && in_valid && !stop;
        len_clamped = LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
        cnt_inc     = (&match_cnt) ? match_cnt : match_cnt + CNT_W'(1);
    end

    seq_match_core #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_run),
        .shift_en (shift_en),
        .in_bit   (in_bit),
        .pattern  (pattern_q),
        .len      (len_q),
        .overlap  (overlap_q),
        .hit      (hit)
    );

    // Controller FSM with config registers, match counter and registered flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            target_q  <= '0;
            match     <= 1'b0;
            match_cnt <= '0;
            done      <= 1'b0;
        end else begin
            match <= 1'b0;
            if (accept) begin
                pattern_q <= cfg_pattern;
                len_q     <= len_clamped;
                overlap_q <= cfg_overlap;
                target_q  <= cfg_target;
                match_cnt <= '0;
                done      <= 1'b0;
                state     <= ARMED;
            end else begin
                case (state)
                    ARMED, DONE: begin
                        if (start_run) begin
                            match_cnt <= '0;
                            done      <= 1'b0;
                            state     <= RUN;
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            state <= ARMED;
                        end else if (hit) begin
                            match     <= 1'b1;
                            match_cnt <= cnt_inc;
                            if ((target_q != '0) && (cnt_inc == target_q)) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SEQ_DET_CTRL_POS_EN
    // Position reporting: bit index within the run and index of the last hit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt  <= '0;
            last_pos <= '0;
        end else if (start_run) begin
            bit_cnt  <= '0;
            last_pos <= '0;
        end else if (shift_en) begin
            bit_cnt <= bit_cnt + 16'd1;
            if (hit)
                last_pos <= bit_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_det_ctrl
//  Brief    : Self-checking bench for seq_det_ctrl. A behavioural model keeps
//             the received bit history as a queue and decides matches by
//             comparing its tail with the configured pattern.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_det_ctrl;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 8;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_RUN   = 2;
    localparam int M_DONE  = 3;

    logic               clk;
    logic               rst;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;
    logic               start;
    logic               stop;
    logic               in_valid;
    logic               in_bit;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;
    logic               busy;
    logic               done;
`ifdef SEQ_DET_CTRL_POS_EN
    logic [15:0]        bit_cnt;
    logic [15:0]        last_pos;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    int     m_state;
    bit     m_match;
    bit     m_done;
    int     m_cnt;
    bit [7:0] m_pat;
    int     m_len;
    bit     m_ov;
    int     m_tgt;
    bit     m_hist[$];
    int     m_bitcnt;
    int     m_lastpos;

    seq_det_ctrl #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .start       (start),
        .stop        (stop),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .match       (match),
        .match_cnt   (match_cnt),
        .busy        (busy),
        .done        (done)
`ifdef SEQ_DET_CTRL_POS_EN
        ,
        .bit_cnt     (bit_cnt),
        .last_pos    (last_pos)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_state   = M_IDLE;
        m_match   = 1'b0;
        m_done    = 1'b0;
        m_cnt     = 0;
        m_pat     = '0;
        m_len     = 0;
        m_ov      = 1'b0;
        m_tgt     = 0;
        m_hist.delete();
        m_bitcnt  = 0;
        m_lastpos = 0;
    endtask

    // Pattern ends with the most recently received bit: pattern bit k must
    // equal the bit received k places before the newest one.
    function automatic bit tail_matches();
        if (m_hist.size() < m_len)
            return 1'b0;
        for (int k = 0; k < m_len; k++)
            if (m_hist[m_hist.size() - 1 - k] != m_pat[k])
                return 1'b0;
        return 1'b1;
    endfunction

    // Advance the model by one clock using the inputs currently applied
    task automatic model_eval();
        bit acc;
        acc     = cfg_valid && (m_state != M_RUN);
        m_match = 1'b0;
        if (acc) begin
            m_pat   = cfg_pattern;
            m_len   = (cfg_len == 0) ? 1 : ((int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len));
            m_ov    = cfg_overlap;
            m_tgt   = cfg_target;
            m_cnt   = 0;
            m_done  = 1'b0;
            m_state = M_ARMED;
        end else if ((m_state == M_ARMED || m_state == M_DONE) && start) begin
            m_hist.delete();
            m_cnt     = 0;
            m_done    = 1'b0;
            m_bitcnt  = 0;
            m_lastpos = 0;
            m_state   = M_RUN;
        end else if (m_state == M_RUN) begin
            if (stop) begin
                m_state = M_ARMED;
            end else if (in_valid) begin
                m_hist.push_back(in_bit);
                if (m_hist.size() > MAX_LEN)
                    void'(m_hist.pop_front());
                m_bitcnt = (m_bitcnt + 1) % 65536;
                if (tail_matches()) begin
                    m_match   = 1'b1;
                    m_lastpos = m_bitcnt;
                    if (m_cnt < 255)
                        m_cnt = m_cnt + 1;
                    if (!m_ov)
                        m_hist.delete();
                    if (m_tgt != 0 && m_cnt == m_tgt) begin
                        m_done  = 1'b1;
                        m_state = M_DONE;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        check_val("match", match, m_match);
        check_val("match_cnt", match_cnt, m_cnt);
        check_val("busy", busy, (m_state == M_RUN));
        check_val("done", done, m_done);
        check_val("cfg_ready", cfg_ready, (m_state != M_RUN));
`ifdef SEQ_DET_CTRL_POS_EN
        check_val("bit_cnt", bit_cnt, m_bitcnt);
        check_val("last_pos", last_pos, m_lastpos);
`endif
    endtask

    task automatic step();
        model_eval();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        cfg_valid   = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        cfg_target  = '0;
        start       = 1'b0;
        stop        = 1'b0;
        in_valid    = 1'b0;
        in_bit      = 1'b0;
    endtask

    task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ov, input logic [7:0] tgt);
        cfg_valid   = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        cfg_target  = tgt;
        step();
        cfg_valid   = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        step();
        in_valid = 1'b0;
    endtask

    // Send n bits MSB first; compare match after each bit with exp_match
    task automatic send_stream(input string tag, input logic [15:0] bits, input logic [15:0] exp_match, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(bits[i]);
            check_val(tag, match, exp_match[i]);
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b1;

        // 1: overlapping 1011 on 1011011
        do_cfg({4'b0000, seq_det_pkg::PATTERN_DEFAULT}, 4'd4, 1'b1, 8'd0);
        do_start();
        send_stream("t1_match", 16'b1011011, 16'b0001001, 7);
        check_val("t1_cnt", match_cnt, 2);
        check_val("t1_busy", busy, 1);

        // 2: non-overlapping, same stream
        do_stop();
        do_cfg(8'b1011, 4'd4, 1'b0, 8'd0);
        do_start();
        send_stream("t2_match", 16'b1011011, 16'b0001000, 7);
        check_val("t2_cnt", match_cnt, 1);

        // 3: target 2 on 11 with 11111
        do_stop();
        do_cfg(8'b11, 4'd2, 1'b0, 8'd2);
        do_start();
        send_stream("t3_match", 16'b11111, 16'b01010, 5);
        check_val("t3_done", done, 1);
        check_val("t3_cnt", match_cnt, 2);
        check_val("t3_ready", cfg_ready, 1);
        check_val("t3_busy", busy, 0);

        // 4: config refused while running, stop beats start
        do_start();
        send_stream("t4_match", 16'b11, 16'b01, 2);
        cfg_valid   = 1'b1;
        cfg_pattern = 8'b000;
        cfg_len     = 4'd3;
        step();
        check_val("t4_ready", cfg_ready, 0);
        cfg_valid = 1'b0;
        stop  = 1'b1;
        start = 1'b1;
        step();
        stop  = 1'b0;
        start = 1'b0;
        check_val("t4_busy", busy, 0);
        check_val("t4_cnt_held", match_cnt, 1);
        do_start();
        send_stream("t4_oldcfg", 16'b11, 16'b01, 2);

        // 5: length clamp
        do_stop();
        do_cfg(8'b10110011, 4'd12, 1'b0, 8'd0);
        do_start();
        send_stream("t5_match", 16'b10110011, 16'b00000001, 8);
        check_val("t5_cnt", match_cnt, 1);

        // 6: async reset mid-pattern
        do_stop();
        do_cfg(8'b1011, 4'd4, 1'b1, 8'd0);
        do_start();
        send_stream("t6_pre", 16'b101, 16'b000, 3);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b1;
        do_cfg(8'b1011, 4'd4, 1'b1, 8'd0);
        do_start();
        send_stream("t6_post", 16'b1, 16'b0, 1);
        check_val("t6_cnt", match_cnt, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            cfg_valid   = ($urandom % 20) == 0;
            cfg_pattern = $urandom;
            cfg_len     = (($urandom % 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 3));
            cfg_overlap = $urandom;
            cfg_target  = 8'($urandom_range(0, 4));
            start       = ($urandom % 8) == 0;
            stop        = ($urandom % 25) == 0;
            in_valid    = ($urandom % 10) < 7;
            in_bit      = $urandom;
            step();
        end
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
